// File: rtl/fsm_walk_sequencer_if.sv
// Command/status bundle between a requester and fsm_walk_sequencer.
// With SEQ_HOP_COUNT_EN defined the bundle also carries hop_count.
interface fsm_walk_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_target;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [1:0] cur_state;
`ifdef SEQ_HOP_COUNT_EN
  logic [1:0] hop_count;

  modport master (
    output cmd_valid, cmd_target,
    input  cmd_ready, busy, done, err_code, cur_state, hop_count
  );

  modport slave (
    input  cmd_valid, cmd_target,
    output cmd_ready, busy, done, err_code, cur_state, hop_count
  );
`else
  modport master (
    output cmd_valid, cmd_target,
    input  cmd_ready, busy, done, err_code, cur_state
  );

  modport slave (
    input  cmd_valid, cmd_target,
    output cmd_ready, busy, done, err_code, cur_state
  );
`endif
endinterface

// File: rtl/fsm_walk_sequencer.sv
// Steps the observable A/B/C FSM to a commanded target one checked hop at a time.
// Define SEQ_HOP_COUNT_EN to add the hop_count status output.
//
// state | meaning
// IDLE  | ready for a command; FSM inputs held at 00
// STEP  | one cycle driving the current hop code
// WAIT  | inputs 00; watch for the expected state, bad observation or timeout
// DONE  | one-cycle done pulse, err_code updated
module fsm_walk_sequencer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_walk_sequencer_if.slave  cmd,
  output logic                 o_fsm_input1,
  output logic                 o_fsm_input2,
  input  logic                 i_obs_output1,
  input  logic                 i_obs_state1,
  input  logic                 i_obs_state0
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ST_A    = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_C    = 2'd2;
  localparam logic [1:0] TGT_ILL = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OBS_BAD = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    r_cur_state;
  logic [1:0]    r_target;
  logic [1:0]    r_expect;
  logic [1:0]    r_err;
  logic [CW-1:0] r_cnt;
  logic          r_in1;
  logic          r_in2;
`ifdef SEQ_HOP_COUNT_EN
  logic [1:0]    r_hop_count;
`endif

  logic [1:0] w_dec;
  logic       w_obs_bad;
  logic [1:0] w_nxt_state;
  logic       w_accept;
  logic       w_enter_step;
  logic       w_enter_done;
  logic       w_cnt_inc;
  logic [1:0] w_err_nxt;
  logic [1:0] w_hop_from;
  logic [1:0] w_hop_tgt;
  logic [3:0] w_hop;

  // Returns {input code, state reached}. B->C routes via A, C->A routes via B.
  function automatic logic [3:0] hop_of(input logic [1:0] from, input logic [1:0] tgt);
    logic [3:0] h;
    case (from)
      ST_A:    h = (tgt == ST_B) ? {2'b01, ST_B} : {2'b10, ST_C};
      ST_B:    h = {2'b11, ST_A};
      default: h = {2'b10, ST_B};
    endcase
    return h;
  endfunction

  assign w_dec     = {i_obs_state1, i_obs_state0};
  assign w_obs_bad = (w_dec == 2'b11) || (i_obs_output1 != (w_dec == ST_B));
  assign w_hop_tgt = w_accept ? cmd.cmd_target : r_target;
  assign w_hop     = hop_of(w_hop_from, w_hop_tgt);

  always_comb begin
    w_nxt_state  = r_state;
    w_accept     = 1'b0;
    w_enter_step = 1'b0;
    w_enter_done = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_nxt    = r_err;
    w_hop_from   = r_cur_state;
    case (r_state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          w_accept = 1'b1;
          if (cmd.cmd_target == TGT_ILL) begin
            w_nxt_state  = S_DONE;
            w_enter_done = 1'b1;
            w_err_nxt    = ERR_ILLEGAL;
          end else if (cmd.cmd_target == r_cur_state) begin
            w_nxt_state  = S_DONE;
            w_enter_done = 1'b1;
            w_err_nxt    = ERR_OK;
          end else begin
            w_nxt_state  = S_STEP;
            w_enter_step = 1'b1;
            w_hop_from   = r_cur_state;
          end
        end
      end
      S_STEP: begin
        w_nxt_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_obs_bad) begin
          w_nxt_state  = S_DONE;
          w_enter_done = 1'b1;
          w_err_nxt    = ERR_OBS_BAD;
        end else if (w_dec == r_expect) begin
          if (r_expect == r_target) begin
            w_nxt_state  = S_DONE;
            w_enter_done = 1'b1;
            w_err_nxt    = ERR_OK;
          end else begin
            w_nxt_state  = S_STEP;
            w_enter_step = 1'b1;
            w_hop_from   = r_expect;
          end
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_nxt_state  = S_DONE;
          w_enter_done = 1'b1;
          w_err_nxt    = ERR_TIMEOUT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_state <= ST_A;
      r_target    <= ST_A;
      r_expect    <= ST_A;
      r_err       <= ERR_OK;
      r_cnt       <= '0;
      r_in1       <= 1'b0;
      r_in2       <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (!w_obs_bad) begin
        r_cur_state <= w_dec;
      end
      if (w_accept) begin
        r_target <= cmd.cmd_target;
      end
      // Inputs are only non-zero for the single STEP cycle after a hop is launched.
      if (w_enter_step) begin
        {r_in1, r_in2} <= w_hop[3:2];
        r_expect       <= w_hop[1:0];
        r_cnt          <= '0;
      end else begin
        {r_in1, r_in2} <= 2'b00;
        if (w_cnt_inc) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_enter_done) begin
        r_err <= w_err_nxt;
      end
    end
  end

`ifdef SEQ_HOP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hop_count <= 2'd0;
    end else if (w_accept) begin
      r_hop_count <= {1'b0, w_enter_step};
    end else if (w_enter_step) begin
      r_hop_count <= r_hop_count + 2'd1;
    end
  end

  assign cmd.hop_count = r_hop_count;
`endif

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign cmd.busy      = (r_state != S_IDLE);
  assign cmd.done      = (r_state == S_DONE);
  assign cmd.err_code  = r_err;
  assign cmd.cur_state = r_cur_state;
  assign o_fsm_input1  = r_in1;
  assign o_fsm_input2  = r_in2;

endmodule

// File: tb/tb_fsm_walk_sequencer.sv
// Scoreboard bench for fsm_walk_sequencer driving a behavioural A/B/C FSM.
// Expectations come from a path-search reference over the FSM's hop graph.
module tb_fsm_walk_sequencer;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset;
  logic in1, in2;
  logic obs_o1, obs_s1, obs_s0;

  fsm_walk_sequencer_if ifc();

  fsm_walk_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (ifc),
    .o_fsm_input1  (in1),
    .o_fsm_input2  (in2),
    .i_obs_output1 (obs_o1),
    .i_obs_state1  (obs_s1),
    .i_obs_state0  (obs_s0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err; int cur; int hops; int lat; int np; int p0; int p1;
  } exp_t;

  exp_t sb[$];
  int   hop_code [3][3];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   ref_st = 0;
  int   last_err = 0;

  // Behavioural FSM: moves along a hop-graph edge whose code matches the inputs.
  int fsm_st;
  bit freeze;
  int obs_force;

  always @(posedge clk or posedge reset) begin
    if (reset) fsm_st <= 0;
    else if (!freeze) begin
      for (int n = 0; n < 3; n++)
        if (hop_code[fsm_st][n] != 0 && hop_code[fsm_st][n] == int'({in1, in2}))
          fsm_st <= n;
    end
  end

  assign obs_s1 = (obs_force == 1) ? 1'b1 : (fsm_st == 2);
  assign obs_s0 = (obs_force == 1) ? 1'b1 : (fsm_st == 1);
  assign obs_o1 = (fsm_st == 1) ^ (obs_force == 2);

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int start, input int tgt, input int mode);
    exp_t e;
    e.err = 0; e.cur = start; e.hops = 0; e.lat = 0; e.np = 0; e.p0 = 0; e.p1 = 0;
    if (tgt == 3) begin e.err = 1; return e; end
    if (tgt == start) return e;
    if (hop_code[start][tgt] != 0) begin
      e.np = 1; e.p0 = hop_code[start][tgt];
    end else begin
      for (int m = 0; m < 3; m++)
        if (m != start && m != tgt && hop_code[start][m] != 0 && hop_code[m][tgt] != 0) begin
          e.np = 2; e.p0 = hop_code[start][m]; e.p1 = hop_code[m][tgt];
        end
    end
    if (mode == 1) begin
      e.err = 2; e.np = 1; e.hops = 1; e.lat = 1 + T;
    end else if (mode == 2) begin
      e.err = 3; e.np = 1; e.hops = 1; e.lat = 2;
    end else begin
      e.cur = tgt; e.hops = e.np; e.lat = 2 * e.np;
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: tracks accepts and input pulses, pops and compares on every done.
  initial begin
    int  acc_cyc, npl, pl0, pl1;
    bit  post_chk, stray;
    exp_t e;
    acc_cyc = 0; npl = 0; pl0 = 0; pl1 = 0; post_chk = 0; stray = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        post_chk = 0; npl = 0; stray = 0;
      end else begin
        if (post_chk) begin
          chk("ready_after_done", int'(ifc.cmd_ready), 1);
          chk("busy_after_done", int'(ifc.busy), 0);
          chk("err_held", int'(ifc.err_code), last_err);
          post_chk = 0;
        end
        if (ifc.cmd_valid && ifc.cmd_ready) begin
          acc_cyc = cyc + 1; npl = 0; stray = 0;
        end
        if ({in1, in2} != 2'b00) begin
          if (!ifc.busy || ifc.done) stray = 1;
          else begin
            if (npl == 0) pl0 = int'({in1, in2});
            else if (npl == 1) pl1 = int'({in1, in2});
            npl++;
          end
        end
        if (ifc.done) begin
          done_cnt++;
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("err_code", int'(ifc.err_code), e.err);
            chk("cur_state", int'(ifc.cur_state), e.cur);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("pulse_count", npl, e.np);
            if (e.np >= 1) chk("pulse0", pl0, e.p0);
            if (e.np >= 2) chk("pulse1", pl1, e.p1);
            chk("stray_inputs", int'(stray), 0);
            chk("busy_in_done", int'(ifc.busy), 1);
            chk("ready_in_done", int'(ifc.cmd_ready), 0);
`ifdef SEQ_HOP_COUNT_EN
            chk("hop_count", int'(ifc.hop_count), e.hops);
`endif
            last_err = e.err;
            post_chk = 1;
          end
        end
      end
    end
  end

  task automatic issue(input int tgt, input int mode, input bit wait_done);
    exp_t e;
    int n, dc;
    e = model(ref_st, tgt, mode);
    ref_st = e.cur;
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_target = 2'(tgt);
    n = 0;
    while (!ifc.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      chk("accept_timeout", 1, 0);
      void'(sb.pop_back());
      ifc.cmd_valid = 1'b0;
      return;
    end
    dc = done_cnt;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_target = 2'($urandom_range(0, 3));
    if (mode != 0) freeze = 1'b1;
    if (mode == 2) obs_force = int'($urandom_range(1, 2));
    if (wait_done || mode != 0) begin
      n = 0;
      while (done_cnt == dc && n < 200) begin @(posedge clk); n++; end
      if (n >= 200) chk("done_timeout", 1, 0);
      #1;
      freeze = 1'b0;
      obs_force = 0;
    end
  endtask

  initial begin
    exp_t e;
    int n, dc;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) hop_code[a][b] = 0;
    hop_code[0][1] = 1; hop_code[0][2] = 2; hop_code[1][0] = 3; hop_code[2][1] = 2;
    ifc.cmd_valid = 1'b0; ifc.cmd_target = 2'd0;
    freeze = 1'b0; obs_force = 0;
    reset = 1'b1;
    #12;
    chk("rst_ready", int'(ifc.cmd_ready), 1);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_err", int'(ifc.err_code), 0);
    chk("rst_cur", int'(ifc.cur_state), 0);
    chk("rst_inputs", int'({in1, in2}), 0);
`ifdef SEQ_HOP_COUNT_EN
    chk("rst_hop_count", int'(ifc.hop_count), 0);
`endif
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);

    issue(2, 0, 1);   // A->C, one hop
    issue(0, 0, 1);   // C->A via B
    issue(3, 0, 1);   // illegal
    issue(1, 0, 1);   // A->B
    issue(1, 0, 1);   // already at B
    issue(0, 0, 1);   // B->A
    issue(1, 1, 1);   // frozen FSM times out
    issue(2, 0, 1);   // A->C, sets up the two-hop reset case

    // Reset during WAIT of a two-hop command: no done may follow.
    e = model(ref_st, 0, 0);
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1; ifc.cmd_target = 2'd0;
    n = 0;
    while (!ifc.cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_inputs", int'({in1, in2}), 0);
    chk("midrst_busy", int'(ifc.busy), 0);
    chk("midrst_ready", int'(ifc.cmd_ready), 1);
    chk("midrst_done", int'(ifc.done), 0);
    chk("midrst_cur", int'(ifc.cur_state), 0);
    sb.delete();
    ref_st = 0;
    dc = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    chk("no_done_after_reset", done_cnt - dc, 0);

    issue(2, 2, 1);   // bad observation during WAIT

    for (int i = 0; i < 60; i++) begin
      int t, r, mode;
      bit wd;
      t = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      mode = 0;
      wd = 1'b1;
      if (t != 3 && t != ref_st) begin
        if (r == 0) mode = 1;
        else if (r == 1) mode = 2;
      end
      if (mode == 0 && r >= 7) wd = 1'b0;
      issue(t, mode, wd);
      if (wd) repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
